// File: rtl/taylor_cos_sched.sv
// Request sequencer for the taylor_cos datapath: degree reduction, radian coding, latency wait, signed result.
// Optional macro TAYLOR_SCHED_SIN_EN adds req_sin_80 to compute sin(d) as cos(d - 90).
module taylor_cos_sched #(
    parameter int unsigned LAT_80   = 3,
    parameter logic [7:0]  FACT2_80 = 8'd2,
    parameter logic [7:0]  FACT4_80 = 8'd24
) (
    input  logic       clk_80,
    input  logic       reset_80,
    input  logic       req_valid_80,
    output logic       req_ready_80,
    input  logic [8:0] req_deg_80,
`ifdef TAYLOR_SCHED_SIN_EN
    input  logic       req_sin_80,
`endif
    output logic       res_valid_80,
    input  logic       res_ready_80,
    output logic [8:0] res_cos_80,
    output logic       busy_80,
    output logic [7:0] radian_80,
    output logic [7:0] fact2_80,
    output logic [7:0] fact4_80,
    input  logic [7:0] cos_value_80
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RAD_W = 17;

    typedef enum logic [1:0] {S_IDLE, S_RED, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [8:0]         deg_q, deg_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rad_q, rad_d;
    logic [8:0]         res_q, res_d;
    logic               vld_q, vld_d;
    logic [7:0]         f2_q, f4_q;

    logic               accept;
    logic               cnt_last;
    logic [9:0]         deg_norm;
    logic [6:0]         red_a;
    logic               red_neg;
    logic [RAD_W-1:0]   rad_prod;
    logic [8:0]         mag;

    assign accept       = req_valid_80 && (state_q == S_IDLE);
    assign cnt_last     = (cnt_q == CNT_W'(1));
    assign req_ready_80 = (state_q == S_IDLE);
    assign busy_80      = (state_q != S_IDLE);
    assign res_valid_80 = vld_q;
    assign res_cos_80   = res_q;
    assign radian_80    = rad_q;
    assign fact2_80     = f2_q;
    assign fact4_80     = f4_q;

    // State register
    always_ff @(posedge clk_80) begin
        if (reset_80) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RED;
            S_RED:  state_d = S_WAIT;
            S_WAIT: if (cnt_last) state_d = S_DONE;
            S_DONE: if (res_ready_80) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: angle normalisation, quadrant reduction, sign application
    always_comb begin
        deg_d = deg_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        rad_d = rad_q;
        res_d = res_q;
        vld_d = vld_q;

        deg_norm = (req_deg_80 >= 9'd360) ? 10'(req_deg_80) - 10'd360 : 10'(req_deg_80);
`ifdef TAYLOR_SCHED_SIN_EN
        if (req_sin_80) begin
            deg_norm = deg_norm + 10'd270;
            if (deg_norm >= 10'd360) deg_norm = deg_norm - 10'd360;
        end
`endif

        if (deg_q <= 9'd90) begin
            red_a = 7'(deg_q);           red_neg = 1'b0;
        end else if (deg_q <= 9'd180) begin
            red_a = 7'(9'd180 - deg_q);  red_neg = 1'b1;
        end else if (deg_q <= 9'd270) begin
            red_a = 7'(deg_q - 9'd180);  red_neg = 1'b1;
        end else begin
            red_a = 7'(9'd360 - deg_q);  red_neg = 1'b0;
        end
        rad_prod = RAD_W'(red_a) * RAD_W'(572) + RAD_W'(128);

        // Negating a zero magnitude yields zero, so no -0 is ever produced
        mag = {1'b0, cos_value_80};

        case (state_q)
            S_IDLE: if (accept) deg_d = 9'(deg_norm);
            S_RED: begin
                neg_d = red_neg;
                rad_d = 8'(rad_prod >> 8);
                cnt_d = CNT_W'(LAT_80);
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_last) begin
                    res_d = neg_q ? 9'(-mag) : mag;
                    vld_d = 1'b1;
                end
            end
            S_DONE: if (res_ready_80) vld_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_80) begin
        if (reset_80) begin
            deg_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            rad_q <= '0;
            res_q <= '0;
            vld_q <= 1'b0;
            f2_q  <= '0;
            f4_q  <= '0;
        end else begin
            deg_q <= deg_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            rad_q <= rad_d;
            res_q <= res_d;
            vld_q <= vld_d;
            f2_q  <= FACT2_80;
            f4_q  <= FACT4_80;
        end
    end

endmodule

// File: tb/tb_taylor_cos_sched.sv
// Self-checking bench for taylor_cos_sched with a behavioural cosine datapath stand-in.
module tb_taylor_cos_sched;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [8:0] req_deg;
`ifdef TAYLOR_SCHED_SIN_EN
    logic       req_sin;
`endif
    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_cos;
    logic       busy;
    logic [7:0] radian;
    logic [7:0] fact2;
    logic [7:0] fact4;
    logic [7:0] cos_value;

    logic       ovr_en;
    logic [7:0] ovr_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    taylor_cos_sched #(.LAT_80(LAT), .FACT2_80(8'd2), .FACT4_80(8'd24)) dut (
        .clk_80       (clk),
        .reset_80     (reset),
        .req_valid_80 (req_valid),
        .req_ready_80 (req_ready),
        .req_deg_80   (req_deg),
`ifdef TAYLOR_SCHED_SIN_EN
        .req_sin_80   (req_sin),
`endif
        .res_valid_80 (res_valid),
        .res_ready_80 (res_ready),
        .res_cos_80   (res_cos),
        .busy_80      (busy),
        .radian_80    (radian),
        .fact2_80     (fact2),
        .fact4_80     (fact4),
        .cos_value_80 (cos_value)
    );

    // Ideal datapath: round(128*cos(radian code / 128))
    function automatic logic [7:0] dp_model(input logic [7:0] r);
        real x;
        x = 128.0 * $cos(real'(r) / 128.0);
        if (x < 0.0) x = 0.0;
        return 8'($rtoi(x + 0.5));
    endfunction

    always_comb cos_value = ovr_en ? ovr_val : dp_model(radian);

    // Reference: fold angle into 0..90 by distance to the nearest multiple of 180
    function automatic void ref_calc(input int deg, input bit sin, output int rad, output bit neg);
        int d;
        int a;
        d = deg % 360;
        if (sin) d = (d + 270) % 360;
        a = d % 180;
        if (a > 90) a = 180 - a;
        neg = (d > 90) && (d <= 270);
        rad = (a * 572 + 128) / 256;
    endfunction

    function automatic int signed_res(input bit neg, input int v);
        return neg ? ((512 - v) % 512) : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One full request/response; reports radian, result and edges from accept to res_valid
    task automatic transact(input int deg, output int rad, output int res, output int lat);
        int n;
        req_deg   = 9'(deg);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rad = int'(radian);
        res = int'(res_cos);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("ack_valid_low", int'(res_valid), 0);
    endtask

    typedef struct {
        int deg;
        int ov;
        int rad;
        int res;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rad, res, lat, er, ev, hits;
        bit neg;
        real ideal, sres;

        tbl[0] = '{60,  'h40, 'h86, 'h040};
        tbl[1] = '{120, 'h40, 'h86, 'h1C0};
        tbl[2] = '{270, 'h00, 'hC9, 'h000};
        tbl[3] = '{400, 'h50, 'h59, 'h050};
        tbl[4] = '{359, 'h7F, 'h02, 'h07F};
        tbl[5] = '{200, 'h00, 'h2D, 'h000};
        tbl[6] = '{511, 'h70, 'h41, 'h190};
        tbl[7] = '{0,   'h80, 'h00, 'h080};
        tbl[8] = '{180, 'h80, 'h00, 'h180};
        tbl[9] = '{300, 'h40, 'h86, 'h040};

        reset = 1'b1; req_valid = 1'b0; req_deg = '0; res_ready = 1'b0;
        ovr_en = 1'b1; ovr_val = '0;
`ifdef TAYLOR_SCHED_SIN_EN
        req_sin = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_cos",   int'(res_cos),   0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_radian",    int'(radian),    0);
        chk("rst_fact2",     int'(fact2),     0);
        chk("rst_fact4",     int'(fact4),     0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("fact2_load", int'(fact2), 2);
        chk("fact4_load", int'(fact4), 24);

        // Directed table with fixed datapath responses
        foreach (tbl[i]) begin
            ovr_val = 8'(tbl[i].ov);
            transact(tbl[i].deg, rad, res, lat);
            chk($sformatf("tbl%0d_rad", i), rad, tbl[i].rad);
            chk($sformatf("tbl%0d_res", i), res, tbl[i].res);
            chk($sformatf("tbl%0d_lat", i), lat, LAT + 1);
        end

        // Sweep with the ideal datapath
        ovr_en = 1'b0;
        for (int d = 0; d < 360; d += 10) begin
            transact(d, rad, res, lat);
            ref_calc(d, 1'b0, er, neg);
            ev = signed_res(neg, int'(dp_model(8'(er))));
            chk($sformatf("sweep%0d_rad", d), rad, er);
            chk($sformatf("sweep%0d_res", d), res, ev);
            sres  = (res >= 256) ? real'(res - 512) : real'(res);
            ideal = 128.0 * $cos(real'(d) * 3.14159265358979 / 180.0);
            checks++;
            if (sres - ideal > 1.0001 || ideal - sres > 1.0001) begin
                errors++;
                $display("FAIL sweep%0d_tol actual=%0f ideal=%0f", d, sres, ideal);
            end
        end

        // Randomised requests against the reference
        for (int k = 0; k < 25; k++) begin
            int dg;
            dg = int'($urandom_range(0, 511));
            ovr_en  = 1'($urandom_range(0, 1));
            ovr_val = 8'($urandom_range(0, 128));
            transact(dg, rad, res, lat);
            ref_calc(dg, 1'b0, er, neg);
            ev = signed_res(neg, ovr_en ? int'(ovr_val) : int'(dp_model(8'(er))));
            chk($sformatf("rnd%0d_deg%0d_rad", k, dg), rad, er);
            chk($sformatf("rnd%0d_deg%0d_res", k, dg), res, ev);
            chk($sformatf("rnd%0d_lat", k), lat, LAT + 1);
        end

        // Backpressure in DONE with a pending request held by the requester
        ovr_en = 1'b0;
        ref_calc(60, 1'b0, er, neg);
        ev = signed_res(neg, int'(dp_model(8'(er))));
        req_deg = 9'd60; req_valid = 1'b1;
        @(posedge clk); #1;
        req_deg = 9'd100;
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_lat", lat, LAT + 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_res_cos",   int'(res_cos),   ev);
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_rel_valid", int'(res_valid), 0);
        chk("bp_rel_ready", int'(req_ready), 1);
        chk("bp_rel_busy",  int'(busy),      0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_accept_busy", int'(busy), 1);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        ref_calc(100, 1'b0, er, neg);
        chk("bp_second_rad", int'(radian), er);
        chk("bp_second_lat", lat, LAT + 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset while waiting on the datapath
        req_deg = 9'd200; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_res_valid", int'(res_valid), 0);
        chk("mrst_res_cos",   int'(res_cos),   0);
        chk("mrst_busy",      int'(busy),      0);
        chk("mrst_req_ready", int'(req_ready), 1);
        chk("mrst_radian",    int'(radian),    0);
        chk("mrst_fact2",     int'(fact2),     0);
        reset = 1'b0;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (res_valid) hits++;
        end
        chk("mrst_no_valid", hits, 0);
        chk("mrst_fact4", int'(fact4), 24);

`ifdef TAYLOR_SCHED_SIN_EN
        req_sin = 1'b1;
        transact(30, rad, res, lat);
        req_sin = 1'b0;
        ref_calc(30, 1'b1, er, neg);
        chk("sin30_rad", rad, 'h86);
        chk("sin30_ref_rad", rad, er);
        chk("sin30_sign", res >> 8, 0);
        chk("sin30_lat", lat, LAT + 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/taylor_cos_sched.md
Name: taylor_cos_sched

Overview:
- Request sequencer in front of the `taylor_cos` datapath.
- Accepts an angle in whole degrees (0..511) on a valid/ready handshake and reduces it modulo 360 and by quadrant to 0..90°.
- Converts the reduced angle to the datapath's Q1.7 radian code and drives `radian_80`, `fact2_80` and `fact4_80`. Waits the datapath latency, captures `cos_value_80`, applies the quadrant sign, and returns a signed result on a second valid/ready handshake.
- One request in flight at a time.

Parameters:
- `LAT_80`, 3: cycles from `radian_80` stable to `cos_value_80` valid; legal range 1..15.
- `FACT2_80`, 8'd2: 2! constant driven to the datapath.
- `FACT4_80`, 8'd24: 4! constant driven to the datapath.

Ports:
- `clk_80` input 1: clock.
- `reset_80` input 1: synchronous, active-high reset.
- `req_valid_80` input 1: request valid.
- `req_ready_80` output 1: high only in IDLE.
- `req_deg_80` input 9: angle in degrees, 0..511.
- `res_valid_80` output 1: result valid.
- `res_ready_80` input 1: result accepted.
- `res_cos_80` output 9: signed two's-complement Q1.7 cosine.
- `busy_80` output 1: high when not in IDLE.
- `radian_80` output 8: to datapath, Q1.7 radians.
- `fact2_80` output 8: to datapath.
- `fact4_80` output 8: to datapath.
- `cos_value_80` input 8: from datapath, unsigned Q1.7 magnitude.

Behaviour:
- Clocking and reset: single clock `clk_80`. Reset `reset_80` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - `req_ready_80` = 1 (combinational from IDLE).
  - `res_valid_80` = 0, `res_cos_80` = 0, `busy_80` = 0.
  - `radian_80` = 0, `fact2_80` = 0, `fact4_80` = 0.
  - Counter = 0.
- `fact2_80`/`fact4_80` load `FACT2_80`/`FACT4_80` on the first edge after reset deasserts, then hold.
- FSM has four states: IDLE, RED, WAIT, DONE.
- IDLE: `req_valid_80` & `req_ready_80` at edge T0 latches the angle:
  - d = `req_deg_80` if < 360, else `req_deg_80` − 360.
  - Next state RED.
- RED, one cycle, reduces by quadrant:
  - d 0..90: a = d, neg = 0.
  - d 91..180: a = 180 − d, neg = 1.
  - d 181..270: a = d − 180, neg = 1.
  - d 271..359: a = 360 − d, neg = 0.
  - `radian_80` <= (a*572 + 128) >> 8. This is an 17-bit intermediate, result ≤ 201 (90° → 0xC9).
  - Counter <= `LAT_80`. Next state WAIT.
- WAIT: counter decrements each edge.
  - On the edge where counter == 1: `res_cos_80` <= neg ? −{1'b0,`cos_value_80`} : {1'b0,`cos_value_80`}; `res_valid_80` <= 1; next state DONE.
  - `res_valid_80` is therefore high from edge T0+LAT_80+1 onward.
- DONE: holds `res_valid_80` and `res_cos_80` stable until `res_valid_80` & `res_ready_80` at an edge.
  - On that edge: `res_valid_80` <= 0, next state IDLE.
  - A new request is accepted no earlier than the following edge; there is no bypass.
- Zero magnitude: a `cos_value_80` of 0 with neg = 1 yields 9'h000, never −0.
- `radian_80` holds its value after capture until the next RED.
- Requests presented while `req_ready_80` = 0 are ignored; the requester must hold them.
- `res_ready_80` asserted outside DONE has no effect.
- Reset mid-operation: at any state, the next edge with `reset_80` = 1 forces all reset values. Any in-flight request is dropped and no `res_valid_80` pulse is produced.

Optional Feature:
- Macro: `TAYLOR_SCHED_SIN_EN`.
- When defined:
  - Adds input `req_sin_80` (1 bit), sampled with the request.
  - When 1, d' = (d + 270) mod 360 before quadrant reduction, computing sin(d) = cos(d − 90).
  - All latency is unchanged.
- When undefined: the port is absent and the block computes cosine only.

Test Plan:
- Reset then 60° request, model returns 0x40 (LAT_80 = 3) → `radian_80` = 0x86; `res_valid_80` rises 4 edges after accept; `res_cos_80` = 9'h040.
- 120° request, model returns 0x40 → `radian_80` = 0x86, neg; `res_cos_80` = 9'h1C0 (−64). 270° request, model returns 0x00 → `radian_80` = 0xC9; `res_cos_80` = 9'h000.
- Sweep 0..359 in 10° steps, model = round(128·cos(a))
  - Radian codes are checked, e.g. 10° → 0x16, 30° → 0x43.
  - Sign is checked per quadrant.
  - `res_cos_80` is within ±1 LSB of 128·cos(d).
- 400° request → reduced to 40°; `radian_80` = 0x59; 359° → a = 1, `radian_80` = 0x02.
- Backpressure: hold `res_ready_80` = 0 for 5 cycles in DONE while `req_valid_80` = 1 → `res_cos_80` stable, `req_ready_80` = 0, no second accept. Release → IDLE and accept exactly one cycle later.
- Assert `reset_80` during WAIT → next edge all outputs at reset values, no `res_valid_80`. With `TAYLOR_SCHED_SIN_EN`, 30° with `req_sin_80` = 1 → d' = 300, `radian_80` = 0x86, positive sign.
